// File: rtl/call_registry.sv
// Floor call registry: per-floor button synchroniser/debouncer, request lamps, SCAN direction FSM
// and nearest-target output. Define CALL_CANCEL_EN to let a second press cancel a lit request.
module call_registry #(
    parameter int NUM_FLOORS      = 3,
    parameter int FLOOR_W         = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn_n,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic                  at_floor,
    output logic [NUM_FLOORS-1:0] led,
    output logic                  pending,
    output logic [1:0]            dir,
    output logic [FLOOR_W-1:0]    target,
    output logic                  target_vld,
    output logic                  floor_err
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_UP   = 2'b01,
        S_DOWN = 2'b10
    } state_t;

    logic [NUM_FLOORS-1:0] sync1, sync2, db, db_prev, armed, press, led_nxt;
    logic [CNT_W-1:0]      cnt [NUM_FLOORS];
    logic [1:0]            live;
    logic                  floor_bad, above, below;
    logic [FLOOR_W-1:0]    up_tgt, dn_tgt;
    int                    floor_x;
    state_t                state, state_nxt;

    assign floor_x   = int'(floor);
    assign floor_bad = {1'b0, floor} >= (FLOOR_W + 1)'(NUM_FLOORS);

    // live[1] marks sync2 as holding a real sample rather than its reset value; a channel only
    // arms once it has really been seen released, so a button held across reset is not a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= '1;
            sync2   <= '1;
            db      <= '1;
            db_prev <= '1;
            armed   <= '0;
            live    <= '0;
            for (int i = 0; i < NUM_FLOORS; i++) cnt[i] <= '0;
        end else begin
            sync1   <= btn_n;
            sync2   <= sync1;
            db_prev <= db;
            live    <= {live[0], 1'b1};
            armed   <= armed | (sync2 & {NUM_FLOORS{live[1]}});
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db[i]  <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press = db_prev & ~db & armed;

    // The clear is applied last so it wins over a same-cycle press.
    always_comb begin
        led_nxt = led;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (press[i]) begin
`ifdef CALL_CANCEL_EN
                led_nxt[i] = ~led[i];
`else
                led_nxt[i] = 1'b1;
`endif
            end
            if (at_floor && !floor_bad && (floor == FLOOR_W'(i))) led_nxt[i] = 1'b0;
        end
    end

    always_comb begin
        above  = 1'b0;
        below  = 1'b0;
        up_tgt = '0;
        dn_tgt = '0;
        for (int j = NUM_FLOORS - 1; j >= 0; j--) begin
            if (led[j] && (j > floor_x)) begin
                above  = 1'b1;
                up_tgt = FLOOR_W'(j);
            end
        end
        for (int j = 0; j < NUM_FLOORS; j++) begin
            if (led[j] && (j < floor_x)) begin
                below  = 1'b1;
                dn_tgt = FLOOR_W'(j);
            end
        end
    end

    // Direction FSM: state register (also holds lamps, target and error flag)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            led        <= '0;
            target     <= '0;
            target_vld <= 1'b0;
            floor_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            led        <= led_nxt;
            floor_err  <= floor_bad;
            target_vld <= (state_nxt != S_IDLE);
            if (state_nxt == S_UP)        target <= up_tgt;
            else if (state_nxt == S_DOWN) target <= dn_tgt;
        end
    end

    // Direction FSM: next state
    always_comb begin
        state_nxt = state;
        if (floor_bad) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = above ? S_UP   : (below ? S_DOWN : S_IDLE);
                S_UP:    state_nxt = above ? S_UP   : (below ? S_DOWN : S_IDLE);
                S_DOWN:  state_nxt = below ? S_DOWN : (above ? S_UP   : S_IDLE);
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Direction FSM: outputs
    always_comb begin
        dir     = state;
        pending = |led;
    end

endmodule

// File: tb/tb_call_registry.sv
// Bench for call_registry: directed scenarios followed by random button/floor traffic, all
// compared against a behavioural model of the call registry's rules.
module tb_call_registry;

    localparam int N  = 3;
    localparam int FW = 2;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  btn_n;
    logic [FW-1:0] floor;
    logic          at_floor;
    logic [N-1:0]  led;
    logic          pending;
    logic [1:0]    dir;
    logic [FW-1:0] target;
    logic          target_vld;
    logic          floor_err;

    int checks   = 0;
    int failures = 0;

    call_registry #(.NUM_FLOORS(N), .FLOOR_W(FW), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .btn_n(btn_n), .floor(floor), .at_floor(at_floor),
        .led(led), .pending(pending), .dir(dir), .target(target),
        .target_vld(target_vld), .floor_err(floor_err)
    );

    always #5 clk = ~clk;

    // Behavioural model
    logic [N-1:0]  m_led, m_db, m_arm, m_press, new_press, smp;
    logic [1:0]    m_dir, nd;
    logic [FW-1:0] m_tgt;
    logic          m_vld, m_err;
    logic [N-1:0]  hist[$];
    int            run[N];
    int            fl, up_t, dn_t;
    bit            above, below, real_s;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_led = '0; m_dir = 2'b00; m_tgt = '0; m_vld = 1'b0; m_err = 1'b0;
            m_db = '1; m_arm = '0; m_press = '0;
            hist.delete();
            for (int i = 0; i < N; i++) run[i] = 0;
        end else begin
            fl = int'(floor);
            above = 0; below = 0; up_t = 0; dn_t = 0;
            for (int j = 0; j < N; j++) begin
                if (m_led[j] && j > fl && !above) begin above = 1; up_t = j; end
                if (m_led[j] && j < fl) begin below = 1; dn_t = j; end
            end
            if (fl >= N)            nd = 2'b00;
            else if (m_dir == 2'b10) nd = below ? 2'b10 : (above ? 2'b01 : 2'b00);
            else                    nd = above ? 2'b01 : (below ? 2'b10 : 2'b00);
            m_vld = (nd != 2'b00);
            if (nd == 2'b01) m_tgt = FW'(up_t);
            if (nd == 2'b10) m_tgt = FW'(dn_t);
            m_dir = nd;
            m_err = (fl >= N);
            for (int i = 0; i < N; i++) begin
                if (m_press[i]) begin
`ifdef CALL_CANCEL_EN
                    m_led[i] = ~m_led[i];
`else
                    m_led[i] = 1'b1;
`endif
                end
                if (at_floor && fl == i) m_led[i] = 1'b0;
            end
            // synchronised sample is the button as captured two edges ago
            real_s = (hist.size() >= 2);
            smp = real_s ? hist[hist.size()-2] : '1;
            new_press = '0;
            for (int i = 0; i < N; i++) begin
                if (smp[i] == m_db[i]) begin
                    run[i] = 0;
                end else begin
                    run[i]++;
                    if (run[i] == D) begin
                        m_db[i] = smp[i];
                        run[i] = 0;
                        if (!smp[i] && m_arm[i]) new_press[i] = 1'b1;
                    end
                end
                if (real_s && smp[i]) m_arm[i] = 1'b1;
            end
            m_press = new_press;
            hist.push_back(btn_n);
            if (hist.size() > 3) void'(hist.pop_front());
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("model_led", 32'(led), 32'(m_led));
        chk("model_pending", 32'(pending), 32'(|m_led));
        chk("model_dir", 32'(dir), 32'(m_dir));
        chk("model_target", 32'(target), 32'(m_tgt));
        chk("model_target_vld", 32'(target_vld), 32'(m_vld));
        chk("model_floor_err", 32'(floor_err), 32'(m_err));
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        reset = 1'b1; btn_n = '1; floor = '0; at_floor = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_led", 32'(led), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_dir", 32'(dir), 0);
        chk("rst_target", 32'(target), 0);
        chk("rst_vld", 32'(target_vld), 0);
        chk("rst_err", 32'(floor_err), 0);
        reset = 1'b0;
        repeat (4) step();

        // clean press on floor 2: lamp after exactly 7 edges, direction one edge later
        btn_n[2] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("t1_led_early", 32'(led), 0);
        end
        step();
        chk("t1_led", 32'(led), 32'b100);
        chk("t1_pending", 32'(pending), 1);
        step();
        chk("t1_dir", 32'(dir), 32'b01);
        chk("t1_target", 32'(target), 2);
        chk("t1_vld", 32'(target_vld), 1);

        // clear at floor 1 with lamps 011
        btn_n[2] = 1'b1; repeat (8) step();
        floor = 2; at_floor = 1'b1; step();
        chk("t2_clear2", 32'(led), 0);
        at_floor = 1'b0;
        btn_n[1:0] = 2'b00; repeat (7) step();
        chk("t2_led011", 32'(led), 32'b011);
        step();
        chk("t2_dir_down", 32'(dir), 32'b10);
        chk("t2_target1", 32'(target), 1);
        floor = 1; at_floor = 1'b1; step();
        chk("t2_led001", 32'(led), 32'b001);
        chk("t2_dir", 32'(dir), 32'b10);
        chk("t2_target0", 32'(target), 0);
        floor = 0; step();
        chk("t2_clear0", 32'(led), 0);
        at_floor = 1'b0; btn_n = '1; repeat (8) step();

        // 3-sample glitch is rejected
        btn_n[1] = 1'b0; repeat (3) step();
        btn_n[1] = 1'b1; repeat (10) step();
        chk("t3_led", 32'(led), 0);
        chk("t3_dir", 32'(dir), 0);

        // press and clear on floor 0 in the same cycle: clear wins
        btn_n[0] = 1'b0; repeat (6) step();
        floor = 0; at_floor = 1'b1; step();
        chk("t4_collision", 32'(led[0]), 0);
        at_floor = 1'b0; step();
        chk("t4_after", 32'(led), 0);
        btn_n[0] = 1'b1; repeat (8) step();

        // out-of-range floor
        btn_n = '0; repeat (7) step();
        chk("t5_led111", 32'(led), 32'b111);
        btn_n = '1; repeat (8) step();
        floor = 3; at_floor = 1'b1; step();
        chk("t5_led_kept", 32'(led), 32'b111);
        chk("t5_err", 32'(floor_err), 1);
        chk("t5_dir", 32'(dir), 0);
        chk("t5_vld", 32'(target_vld), 0);
        floor = 1; at_floor = 1'b0; step();
        chk("t5_err_clear", 32'(floor_err), 0);

        // second press on floor 2
        floor = 2; at_floor = 1'b1; step();
        chk("t6_cleared", 32'(led[2]), 0);
        at_floor = 1'b0;
        btn_n[2] = 1'b0; repeat (7) step();
        chk("t6_first", 32'(led[2]), 1);
        btn_n[2] = 1'b1; repeat (8) step();
        btn_n[2] = 1'b0; repeat (7) step();
`ifdef CALL_CANCEL_EN
        chk("t6_second", 32'(led[2]), 0);
`else
        chk("t6_second", 32'(led[2]), 1);
`endif
        btn_n[2] = 1'b1; repeat (8) step();

        // button held across reset is not a press
        floor = 0; btn_n[0] = 1'b0; repeat (2) step();
        reset = 1'b1; step(); step();
        chk("t7_rst_led", 32'(led), 0);
        chk("t7_rst_dir", 32'(dir), 0);
        reset = 1'b0; repeat (12) step();
        chk("t7_held", 32'(led), 0);
        btn_n[0] = 1'b1; repeat (8) step();
        btn_n[0] = 1'b0; repeat (7) step();
        chk("t7_rearmed", 32'(led[0]), 1);
        btn_n[0] = 1'b1;

        // random traffic
        for (int r = 0; r < 900; r++) begin
            step();
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 9) == 0) btn_n[i] = ~btn_n[i];
            if ($urandom_range(0, 7) == 0) floor = FW'($urandom_range(0, 3));
            at_floor = ($urandom_range(0, 3) == 0);
            reset = (r == 450);
        end
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
